// File: rtl/vram_write_queue.sv
// vram_write_queue: buffers CPU VRAM write strobes in a FIFO and drains them
// to the GPU memories one byte per clock, only while the video timing
// "writable" window is open. CPU writes never stall; excess strobes are
// dropped and flagged with a sticky overflow bit.
module vram_write_queue #(
    parameter int  DEPTH = 16,
    parameter int  AW    = 12,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_address_i,
    input  logic [7:0]    cpu_data_i,
    input  logic          writable_i,
    input  logic          flush_i,
    input  logic          ovf_clear_i,
    output logic [AW-1:0] address_o,
    output logic [7:0]    data_o,
    output logic          vram_we_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o,
    output logic          overflow_o,
    output logic          busy_o
);

    localparam int IW = LW - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Entry storage: {address, data}
    logic [AW+7:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [IW-1:0] wr_idx, rd_idx;

    logic [AW-1:0] address_q;
    logic [7:0]    data_q;
    logic          vram_we_q;
    logic          overflow_q, overflow_d;
    logic          busy_q;
    state_t        state_q, state_d;

    logic full, empty, pop, push, drop;

    assign wr_idx  = wr_ptr_q[IW-1:0];
    assign rd_idx  = rd_ptr_q[IW-1:0];
    assign count_q = wr_ptr_q - rd_ptr_q;
    assign full    = (wr_ptr_q[LW-1] != rd_ptr_q[LW-1]) && (wr_idx == rd_idx);
    assign empty   = (wr_ptr_q == rd_ptr_q);

    // Transfer decisions for this edge; a pop frees the slot a full-FIFO push needs
    always_comb begin
        pop  = writable_i && !empty && !flush_i;
        push = cpu_we_i && !flush_i && (!full || pop);
        drop = cpu_we_i && !flush_i && full && !pop;

        wr_ptr_d = wr_ptr_q + (push ? LW'(1) : LW'(0));
        rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + (pop ? LW'(1) : LW'(0));
        count_d  = wr_ptr_d - rd_ptr_d;

        // A drop on the same edge as a clear leaves the flag set
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clear_i) begin
            overflow_d = 1'b0;
        end
    end

    // Next FSM state from the post-edge entry count and the current window
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (push) begin
                        state_d = writable_i ? ST_DRAIN : ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (count_d == '0) begin
                        state_d = ST_IDLE;
                    end else if (!writable_i) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (writable_i) begin
                        state_d = (count_d == '0) ? ST_IDLE : ST_DRAIN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Entry RAM write port; no reset so it maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_idx] <= {cpu_address_i, cpu_data_i};
        end
    end

    // Pointers, FSM and registered VRAM-side outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            address_q  <= '0;
            data_q     <= '0;
            vram_we_q  <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            busy_q     <= (state_d != ST_IDLE);
            vram_we_q  <= pop;
            if (pop) begin
                {address_q, data_q} <= mem_q[rd_idx];
            end
        end
    end

    assign address_o  = address_q;
    assign data_o     = data_q;
    assign vram_we_o  = vram_we_q;
    assign full_o     = full;
    assign empty_o    = empty;
    assign level_o    = count_q;
    assign overflow_o = overflow_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_vram_write_queue.sv
// Testbench for vram_write_queue: directed scenarios plus a randomized run,
// all checked against a queue-based model of the write buffer.
module tb_vram_write_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 12;
    localparam int LW    = 5;

    logic          clk;
    logic          rst_n;
    logic          cpu_we;
    logic [AW-1:0] cpu_address;
    logic [7:0]    cpu_data;
    logic          writable;
    logic          flush;
    logic          ovf_clear;
    logic [AW-1:0] address;
    logic [7:0]    data;
    logic          vram_we;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [AW+7:0] mq [$];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;
    logic          m_ovf;

    vram_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cpu_we_i      (cpu_we),
        .cpu_address_i (cpu_address),
        .cpu_data_i    (cpu_data),
        .writable_i    (writable),
        .flush_i       (flush),
        .ovf_clear_i   (ovf_clear),
        .address_o     (address),
        .data_o        (data),
        .vram_we_o     (vram_we),
        .full_o        (full),
        .empty_o       (empty),
        .level_o       (level),
        .overflow_o    (overflow),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_ovf  = 1'b0;
    endtask

    // One clock edge of the buffer described in plain queue terms
    task automatic model_edge();
        bit mfull, p, pu, dr;
        logic [AW+7:0] e;
        mfull = (mq.size() == DEPTH);
        p  = writable && (mq.size() > 0) && !flush;
        pu = cpu_we && !flush && (!mfull || p);
        dr = cpu_we && !flush && mfull && !p;
        m_we = p;
        if (flush) begin
            mq.delete();
        end else begin
            if (p) begin
                e = mq.pop_front();
                {m_addr, m_data} = e;
            end
            if (pu) mq.push_back({cpu_address, cpu_data});
        end
        if (dr) m_ovf = 1'b1;
        else if (ovf_clear) m_ovf = 1'b0;
    endtask

    // Apply inputs, clock once, advance the model, settle just after the edge
    task automatic step(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                        input logic wr, input logic fl, input logic oc);
        cpu_we      = we;
        cpu_address = a;
        cpu_data    = d;
        writable    = wr;
        flush       = fl;
        ovf_clear   = oc;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_we = 0; cpu_address = '0; cpu_data = '0;
        writable = 0; flush = 0; ovf_clear = 0;
        model_reset();
        #12;
        checks++;
        if (vram_we !== 1'b0 || address !== '0 || data !== '0 || overflow !== 1'b0 ||
            busy !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || level !== '0) begin
            failures++;
            $display("FAIL reset_state got we=%0b addr=%h data=%h ovf=%0b busy=%0b empty=%0b full=%0b level=%0d exp we=0 addr=000 data=00 ovf=0 busy=0 empty=1 full=0 level=0",
                     vram_we, address, data, overflow, busy, empty, full, level);
        end
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_single();
        step(1, 12'h3C0, 8'h1B, 1, 0, 0);
        checks++;
        if (vram_we !== 1'b0 || level !== 5'd1) begin
            failures++;
            $display("FAIL single_edgeN got we=%0b level=%0d exp we=0 level=1", vram_we, level);
        end
        step(0, '0, '0, 1, 0, 0);
        checks++;
        if (vram_we !== 1'b1 || address !== 12'h3C0 || data !== 8'h1B) begin
            failures++;
            $display("FAIL single_emit got we=%0b addr=%h data=%h exp we=1 addr=3c0 data=1b", vram_we, address, data);
        end
        step(0, '0, '0, 1, 0, 0);
        checks++;
        if (vram_we !== 1'b0 || level !== 5'd0 || busy !== 1'b0 || address !== 12'h3C0) begin
            failures++;
            $display("FAIL single_after got we=%0b level=%0d busy=%0b addr=%h exp we=0 level=0 busy=0 addr=3c0",
                     vram_we, level, busy, address);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) step(1, AW'(i), 8'hA0 + 8'(i), 0, 0, 0);
        step(1, 12'h010, 8'hB0, 0, 0, 0);
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || level !== 5'd16 || vram_we !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fill_overflow got full=%0b ovf=%0b level=%0d we=%0b busy=%0b exp full=1 ovf=1 level=16 we=0 busy=1",
                     full, overflow, level, vram_we, busy);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, '0, '0, 1, 0, 0);
            checks++;
            if (vram_we !== 1'b1 || address !== AW'(i) || data !== 8'hA0 + 8'(i)) begin
                failures++;
                $display("FAIL fill_drain[%0d] got we=%0b addr=%h data=%h exp we=1 addr=%h data=%h",
                         i, vram_we, address, data, AW'(i), 8'hA0 + 8'(i));
            end
        end
        step(0, '0, '0, 1, 0, 0);
        checks++;
        if (vram_we !== 1'b0 || empty !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL fill_end got we=%0b empty=%0b ovf=%0b exp we=0 empty=1 ovf=1", vram_we, empty, overflow);
        end
        step(0, '0, '0, 0, 0, 1);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got ovf=%0b exp ovf=0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) step(1, 12'h100 + AW'(i), 8'($urandom), 0, 0, 0);
        step(1, 12'h1FF, 8'h5A, 1, 0, 0);
        checks++;
        if (level !== 5'd16 || overflow !== 1'b0 || vram_we !== 1'b1 || address !== 12'h100) begin
            failures++;
            $display("FAIL full_push_pop got level=%0d ovf=%0b we=%0b addr=%h exp level=16 ovf=0 we=1 addr=100",
                     level, overflow, vram_we, address);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, '0, '0, 1, 0, 0);
            checks++;
            if (vram_we !== m_we || address !== m_addr || data !== m_data) begin
                failures++;
                $display("FAIL full_drain[%0d] got we=%0b addr=%h data=%h exp we=%0b addr=%h data=%h",
                         i, vram_we, address, data, m_we, m_addr, m_data);
            end
        end
        checks++;
        if (address !== 12'h1FF || data !== 8'h5A || empty !== 1'b1) begin
            failures++;
            $display("FAIL full_last got addr=%h data=%h empty=%0b exp addr=1ff data=5a empty=1", address, data, empty);
        end
        step(0, '0, '0, 1, 0, 0);
    endtask

    task automatic test_writable_drop();
        for (int i = 0; i < 8; i++) step(1, 12'h200 + AW'(i), 8'h10 + 8'(i), 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, '0, '0, 1, 0, 0);
            checks++;
            if (vram_we !== 1'b1 || address !== 12'h200 + AW'(k)) begin
                failures++;
                $display("FAIL wdrop_pop[%0d] got we=%0b addr=%h exp we=1 addr=%h", k, vram_we, address, 12'h200 + AW'(k));
            end
        end
        step(0, '0, '0, 0, 0, 0);
        checks++;
        if (vram_we !== 1'b0 || level !== 5'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wdrop_hold got we=%0b level=%0d busy=%0b exp we=0 level=5 busy=1", vram_we, level, busy);
        end
        for (int k = 3; k < 8; k++) begin
            step(0, '0, '0, 1, 0, 0);
            checks++;
            if (vram_we !== 1'b1 || address !== 12'h200 + AW'(k) || data !== 8'h10 + 8'(k)) begin
                failures++;
                $display("FAIL wdrop_resume[%0d] got we=%0b addr=%h data=%h exp we=1 addr=%h data=%h",
                         k, vram_we, address, data, 12'h200 + AW'(k), 8'h10 + 8'(k));
            end
        end
        step(0, '0, '0, 1, 0, 0);
        checks++;
        if (busy !== 1'b0 || vram_we !== 1'b0) begin
            failures++;
            $display("FAIL wdrop_idle got busy=%0b we=%0b exp busy=0 we=0", busy, vram_we);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) step(1, 12'h300 + AW'(i), 8'($urandom), 0, 0, 0);
        step(1, 12'h3FF, 8'hEE, 1, 1, 0);
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || vram_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush got level=%0d empty=%0b we=%0b busy=%0b exp level=0 empty=1 we=0 busy=0",
                     level, empty, vram_we, busy);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, '0, '0, 1, 0, 0);
            checks++;
            if (vram_we !== 1'b0) begin
                failures++;
                $display("FAIL flush_quiet[%0d] got we=%0b exp we=0", i, vram_we);
            end
        end
        for (int i = 0; i < 16; i++) step(1, AW'($urandom), 8'($urandom), 0, 0, 0);
        step(1, 12'h777, 8'h77, 0, 0, 1);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins got ovf=%0b exp ovf=1", overflow);
        end
        step(0, '0, '0, 0, 1, 0);
        checks++;
        if (overflow !== 1'b1 || empty !== 1'b1) begin
            failures++;
            $display("FAIL flush_keeps_ovf got ovf=%0b empty=%0b exp ovf=1 empty=1", overflow, empty);
        end
        step(0, '0, '0, 0, 0, 1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) step(1, 12'h400 + AW'(i), 8'($urandom), 0, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vram_we !== 1'b0 || level !== 5'd0 || busy !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got we=%0b level=%0d busy=%0b empty=%0b exp we=0 level=0 busy=0 empty=1",
                     vram_we, level, busy, empty);
        end
        model_reset();
        #3;
        rst_n = 1'b1;
        step(1, 12'h055, 8'h66, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        checks++;
        if (vram_we !== 1'b1 || address !== 12'h055 || data !== 8'h66) begin
            failures++;
            $display("FAIL post_reset got we=%0b addr=%h data=%h exp we=1 addr=055 data=66", vram_we, address, data);
        end
        step(0, '0, '0, 1, 0, 0);
    endtask

    task automatic test_random();
        int mfail;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 2) != 0, AW'($urandom), 8'($urandom),
                 $urandom_range(0, 99) < ((i % 120) < 60 ? 15 : 85),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
            checks++;
            mfail = 0;
            if (vram_we !== m_we || overflow !== m_ovf || level !== LW'(mq.size()) ||
                full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
                busy !== (mq.size() != 0)) mfail = 1;
            if (m_we && (address !== m_addr || data !== m_data)) mfail = 1;
            if (mfail != 0) begin
                failures++;
                $display("FAIL random[%0d] got we=%0b addr=%h data=%h ovf=%0b level=%0d full=%0b empty=%0b busy=%0b exp we=%0b addr=%h data=%h ovf=%0b level=%0d",
                         i, vram_we, address, data, overflow, level, full, empty, busy,
                         m_we, m_addr, m_data, m_ovf, mq.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_writable_drop();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_write_queue.md
Name: vram_write_queue

Overview:
- Writer end of the GPU VRAM interface; it is the producer of the `address`/`data` write stream that the background and sprite renderers consume into PMB/NTBL.
- Accepts single-cycle CPU write strobes at any time and buffers them in a FIFO.
- Drains the FIFO to VRAM one byte per clock, and only while the video timing `writable` window is open.
- Sits between the CPU bus decode and the GPU memories, so CPU writes never collide with scanline fetch.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2 and at least 2.
- AW, 12, VRAM byte-address width.
- LW, $clog2(DEPTH)+1, width of the `level` output; derived, do not override.

Ports:
- clk  input  1  GPU pixel clock (12.5875 MHz).
- rst  input  1  asynchronous, active-low reset.
- cpu_we  input  1  single-cycle write strobe from CPU decode; no backpressure.
- cpu_address  input  AW  CPU write address.
- cpu_data  input  8  CPU write data.
- writable  input  1  high while VRAM may be written (from video timing).
- flush  input  1  synchronous discard of all queued entries.
- ovf_clear  input  1  clears the sticky overflow flag.
- address  output  AW  registered VRAM write address.
- data  output  8  registered VRAM write data.
- vram_we  output  1  registered VRAM write enable; address/data valid when high.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- level  output  LW  current entry count.
- overflow  output  1  sticky flag: a strobe was dropped.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - Read/write pointers and count go to 0.
  - address = 0, data = 0, vram_we = 0, overflow = 0, busy = 0.
  - empty = 1, full = 0, level = 0.
  - FSM = IDLE.
  - Reset asserted mid-drain aborts immediately; queued data is lost.
- Storage:
  - DEPTH x (AW+8) array with wrap-around pointers of width $clog2(DEPTH)+1.
  - full = MSBs differ and LSBs equal; empty = pointers equal.
  - level = write pointer minus read pointer, modulo 2^LW.
- Pop condition (evaluated at each posedge): pop = writable && !empty && !flush.
- On pop:
  - address/data load the head entry, vram_we goes to 1, and the read pointer advances.
  - On any edge without a pop, vram_we goes to 0; address/data hold their last value.
- Push condition: push = cpu_we && !flush && (!full || pop).
  - A push while full is accepted when a pop happens on the same edge; count stays DEPTH.
- Drop: cpu_we && !flush && full && !pop.
  - The entry is discarded and overflow is set to 1.
- Simultaneous push and pop on a non-full FIFO: count unchanged.
- Push into an empty FIFO with writable held high:
  - Entry is written at edge N; vram_we is high after edge N+1.
  - Latency is 2 clocks; there is no same-cycle bypass.
- writable sampling:
  - writable is sampled at the edge. When it falls, no pop occurs on that edge and vram_we is low after it.
  - Entries are retained and resume draining in FIFO order on the next rising window.
- flush:
  - Sets the read pointer equal to the write pointer, so count = 0.
  - Forces vram_we to 0 on that edge and discards any same-cycle cpu_we.
  - overflow is unaffected.
- ovf_clear:
  - Clears overflow.
  - If a drop happens on the same edge, set wins and overflow = 1.
- FSM (busy = state != IDLE), next state computed from post-edge count and current writable:
  - IDLE: count 0.
    - Go to DRAIN if a push occurs and writable is high.
    - Go to WAIT if a push occurs and writable is low.
  - DRAIN: pops every cycle.
    - Go to IDLE when the last entry pops with no push.
    - Go to WAIT when writable falls with entries remaining.
  - WAIT: entries held.
    - Go to DRAIN when writable rises.
    - Go to IDLE on flush.
  - Any state goes to IDLE on flush.
- Ordering: VRAM receives writes in strict CPU order; no coalescing, no address checks.

Test Plan:
- Reset, writable=1, single cpu_we with addr 0x3C0 / data 0x1B → vram_we pulses exactly 1 cycle, 2 clocks after the strobe, with address=0x3C0 and data=0x1B; level returns to 0; busy returns low.
- writable=0, 16 strobes (addr 0x000–0x00F, data 0xA0–0xAF), then a 17th → full=1, overflow=1, level=16, no vram_we. Then raise writable → 16 consecutive vram_we cycles with addresses 0x000–0x00F in order.
- FIFO full, writable=1, cpu_we on the same edge as a pop → strobe accepted, level stays 16, overflow stays 0.
- Drain 8 entries, drop writable after 3 pops → vram_we low after the falling edge, level=5, FSM in WAIT. Re-raise writable → remaining 5 entries emitted in order.
- Assert flush with 6 queued entries plus a concurrent cpu_we → level=0, empty=1, vram_we=0, nothing emitted later. Assert ovf_clear together with a drop → overflow stays 1.
- Drop rst asynchronously mid-drain (between clock edges) → vram_we=0, level=0, busy=0 immediately. After release, a new strobe drains normally.
